// File: rtl/serdes_pkg.sv
// Shared types for the serial deserializer.
// Alignment states, symbol type and the idle comma.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CONFIRM,
    LOCKED
  } state_e;

  typedef logic [7:0] symbol_t;

  localparam symbol_t COMMA_SYM = 8'hBC;

  // Bits arrive LSB first, so new bits enter at the top.
  function automatic symbol_t shift_in(
    input symbol_t sr,
    input logic    b
  );
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Small synchronous FIFO with an AXI-Stream read side.
// Head entry is read straight from registered storage.
module axis_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             tvalid,
  output logic [Width-1:0] tdata
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign tvalid  = (count != '0);
  assign full    = (count == FULL_CNT);
  assign tdata   = mem[rd_ptr];
  assign do_pop  = pop & tvalid;
  // A full FIFO still accepts a write when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);

  // Storage writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        do_push & ~do_pop: count <= count + CW'(1);
        do_pop & ~do_push: count <= count - CW'(1);
        default:           count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serdes_deserializer.sv
// Comma-aligned serial-to-byte deserializer.
// Hunts, confirms and tracks byte lock; forwards payload on AXIS.
module serdes_deserializer
  import serdes_pkg::*;
#(
  parameter int      DataWidth    = 8,
  parameter symbol_t Comma        = COMMA_SYM,
  parameter int      ConfirmCount = 3,
  parameter int      LockTimeout  = 64,
  parameter int      FifoDepth    = 4
) (
  input  logic                 ref_clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 bit_valid,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 locked,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int BcW = $clog2(DataWidth);
  localparam int CcW = $clog2(ConfirmCount) + 1;
  localparam int ToW = $clog2(LockTimeout) + 1;

  localparam logic [BcW-1:0] BC_LAST = BcW'(DataWidth - 1);
  localparam logic [CcW-1:0] CC_LAST = CcW'(ConfirmCount - 1);
  localparam logic [ToW-1:0] TO_LAST = ToW'(LockTimeout - 1);

  state_e         state;
  state_e         state_nxt;
  symbol_t        sr;
  symbol_t        window;
  logic [BcW-1:0] bit_cnt;
  logic [BcW-1:0] bit_cnt_nxt;
  logic [CcW-1:0] comma_cnt;
  logic [CcW-1:0] comma_cnt_nxt;
  logic [ToW-1:0] to_cnt;
  logic [ToW-1:0] to_cnt_nxt;
  logic           boundary;
  logic           is_comma;
  logic           push;
  logic           pop;
  logic           full;

  assign window   = shift_in(sr, data_in);
  assign is_comma = (window == Comma);
  assign boundary = bit_valid & (bit_cnt == BC_LAST);
  assign locked   = (state == LOCKED);
  assign pop      = m_axis_tvalid & m_axis_tready;

  // Serial shift register; only valid bits move it.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (bit_valid) begin
      sr <= window;
    end
  end

  // Alignment state and counters.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
    end
  end

  // Next-state logic and payload push decision.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    to_cnt_nxt    = to_cnt;
    push          = 1'b0;
    if (bit_valid) begin
      bit_cnt_nxt = bit_cnt + BcW'(1);
      unique case (state)
        HUNT: begin
          bit_cnt_nxt = '0;
          if (is_comma) begin
            comma_cnt_nxt = CcW'(1);
            state_nxt     = CONFIRM;
          end
        end
        CONFIRM: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_nxt = comma_cnt + CcW'(1);
              if (comma_cnt == CC_LAST) begin
                state_nxt  = LOCKED;
                to_cnt_nxt = '0;
              end
            end else begin
              state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (is_comma) begin
              to_cnt_nxt = '0;
            end else begin
              to_cnt_nxt = to_cnt + ToW'(1);
              if (to_cnt == TO_LAST) begin
                state_nxt = HUNT;
              end else begin
                push = 1'b1;
              end
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Sticky drop flag; a new drop beats the clear.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  axis_sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (ref_clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (window),
    .full      (full),
    .pop       (pop),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata)
  );

endmodule

// File: tb/tb_serdes_deserializer.sv
// Bench for serdes_deserializer.
// Directed bit streams, bit-history model and AXIS scoreboard.
module tb_serdes_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic       bit_valid;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       locked;
  logic       overflow;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx[$];

  logic [7:0] m_q[$];
  logic       m_hist[$];
  int         m_mode;
  int         m_nbits;
  int         m_ncomma;
  int         m_since;
  logic       m_ovf;

  logic       stall;
  logic [7:0] stall_data;

  always #5 clk = ~clk;

  serdes_deserializer dut (
    .ref_clk       (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .bit_valid     (bit_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .locked        (locked),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Last eight received bits, oldest in bit 0.
  function automatic logic [7:0] last_byte();
    logic [7:0] v;
    int n;
    v = '0;
    n = m_hist.size();
    for (int i = 0; i < 8; i++) begin
      if (n - 8 + i >= 0) v[i] = m_hist[n-8+i];
    end
    return v;
  endfunction

  // Reference: mode 0 searching, 1 counting commas, 2 locked.
  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] w;
    logic [7:0] pv;
    bit         push;
    bit         pop;
    bit         ovf_new;
    if (!rst_n) begin
      m_q.delete();
      m_hist.delete();
      m_mode   = 0;
      m_nbits  = 0;
      m_ncomma = 0;
      m_since  = 0;
      m_ovf    = 1'b0;
    end else begin
      pop     = m_axis_tready && (m_q.size() != 0);
      push    = 0;
      pv      = '0;
      ovf_new = 0;
      if (bit_valid) begin
        m_hist.push_back(data_in);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        w = last_byte();
        if (m_mode == 0) begin
          if (w == 8'hBC) begin
            m_mode   = 1;
            m_nbits  = 0;
            m_ncomma = 1;
          end
        end else begin
          m_nbits++;
          if (m_nbits == 8) begin
            m_nbits = 0;
            if (m_mode == 1) begin
              if (w == 8'hBC) begin
                m_ncomma++;
                if (m_ncomma == 3) begin
                  m_mode  = 2;
                  m_since = 0;
                end
              end else begin
                m_mode = 0;
              end
            end else if (w == 8'hBC) begin
              m_since = 0;
            end else begin
              m_since++;
              if (m_since == 64) begin
                m_mode = 0;
              end else begin
                push = 1;
                pv   = w;
              end
            end
          end
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 4) m_q.push_back(pv);
        else ovf_new = 1;
      end
      if (ovf_new) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
  end

  // Scoreboard capture and stall tracking.
  always @(posedge clk) begin
    stall      = rst_n && m_axis_tvalid && !m_axis_tready;
    stall_data = m_axis_tdata;
    if (rst_n && m_axis_tvalid && m_axis_tready) rx.push_back(m_axis_tdata);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("locked", {31'd0, locked}, {31'd0, m_mode == 2});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tdata", {24'd0, m_axis_tdata},
                               {24'd0, m_q[0]});
      if (stall) begin
        chk("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("hold_tdata", {24'd0, m_axis_tdata}, {24'd0, stall_data});
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in   = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lock3();
    repeat (3) send_byte(8'hBC);
  endtask

  task automatic do_reset();
    bit_valid     = 1'b0;
    data_in       = 1'b0;
    clr_overflow  = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    rx.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] junk;
    rst_n         = 1'b0;
    data_in       = 1'b0;
    bit_valid     = 1'b0;
    m_axis_tready = 1'b1;
    clr_overflow  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // Junk prefix then three commas and two payload bytes.
    junk = 8'b0000_1010;
    send_bits(junk, 5);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("pre_lock", {31'd0, locked}, 32'd0);
    send_bit(1'b1);
    chk("lock_3rd_comma", {31'd0, locked}, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(4);
    chk("basic_cnt", rx.size(), 32'd2);
    chk("basic_b0", {24'd0, rx[0]}, 32'h11);
    chk("basic_b1", {24'd0, rx[1]}, 32'h22);

    // Asynchronous reset while locked with a full FIFO.
    do_reset();
    m_axis_tready = 1'b0;
    lock3();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("q_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("q_overflow", {31'd0, overflow}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rx.delete();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    send_byte(8'h33);
    idle(2);
    chk("hunt_locked", {31'd0, locked}, 32'd0);
    chk("hunt_nodata", rx.size(), 32'd0);

    // Confirmation aborted by a non-comma.
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h5A);
    chk("abort_locked", {31'd0, locked}, 32'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_bits(8'hBC, 7);
    chk("relock_pre", {31'd0, locked}, 32'd0);
    send_bit(1'b1);
    chk("relock", {31'd0, locked}, 32'd1);
    send_byte(8'h33);
    idle(3);
    chk("abort_cnt", rx.size(), 32'd1);
    chk("abort_b0", {24'd0, rx[0]}, 32'h33);

    // Backpressure, overflow and clear.
    do_reset();
    m_axis_tready = 1'b0;
    lock3();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    idle(2);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, m_axis_tdata}, 32'h01);
    idle(3);
    m_axis_tready = 1'b1;
    idle(6);
    chk("ovf_cnt", rx.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("ovf_data", {24'd0, rx[i]}, i + 1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Lock timeout after 64 symbols without a comma.
    do_reset();
    lock3();
    for (int i = 0; i < 63; i++) send_byte(8'h40 + 8'(i));
    chk("to_still", {31'd0, locked}, 32'd1);
    send_byte(8'h7F);
    chk("to_drop", {31'd0, locked}, 32'd0);
    idle(3);
    chk("to_cnt", rx.size(), 32'd63);
    chk("to_first", {24'd0, rx[0]}, 32'h40);
    chk("to_last", {24'd0, rx[62]}, 32'h7E);

    // Gaps in bit_valid mid-symbol.
    do_reset();
    lock3();
    send_bits(8'h11, 4);
    repeat (3) begin
      data_in   = 1'($urandom_range(0, 1));
      bit_valid = 1'b0;
      @(negedge clk);
    end
    send_bits(8'h01, 4);
    send_byte(8'h22);
    idle(3);
    chk("gap_cnt", rx.size(), 32'd2);
    chk("gap_b0", {24'd0, rx[0]}, 32'h11);
    chk("gap_b1", {24'd0, rx[1]}, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
